block_row_buffer: RTL and testbench
===================================

BLOCK_ROW_BUFFER -- requirements
Module: block_row_buffer

Interface
REQ-001 SHALL have parameter N, default 2: input lanes per beat; legal values 1, 2, 4 and 8.
REQ-002 SHALL have ports, as listed below:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- en  in  1  stage enable.
- blk_valid  in  1  input beat valid.
- blk_data_y / blk_data_cr / blk_data_cb  in  N x 8 each  pixel lanes.
- blk_sob / blk_eob / blk_sof  in  1 each  start-of-block, end-of-block and start-of-frame markers.
- out_valid  out  1  row valid.
- out_ready  in  1  downstream accept.
- out_y / out_cr / out_cb  out  8 x 8 each  signed level-shifted row.
- out_idx  out  3  row (or column) index.
- out_sof  out  1  first row of a start-of-frame block.
- out_eob  out  1  last row of a block.
- err  out  1  sticky error flag.
REQ-003 SHALL have no flow control on the input side; blk_* beats arrive without backpressure.

Function
REQ-010 SHALL hold two 8x8 storage banks for each of Y, Cr and Cb (ping-pong), plus per-bank full and sof flags.
REQ-011 SHALL accept a beat only when en && blk_valid; all input beats are ignored while en is low.
REQ-012 SHALL, for each accepted beat, write the N lanes to the write bank at (line, elem*N+k) and advance elem (0..8/N-1), then line (0..7).
REQ-013 SHALL, on an accepted beat with blk_sob=1, reset the write position to (0,0) before writing, and capture blk_sof into the bank sof flag.
REQ-014 SHALL, on an accepted beat with blk_eob=1 at position (7, 8/N-1), set the bank full flag and toggle the write bank.
REQ-015 SHALL treat blk_eob at any other position as malformed: set err, leave the bank not full, and reset the write position.
REQ-016 SHALL, when a sob beat targets a write bank that is full, set err and drop every beat up to and including the next eob.
- Exception: a bank whose final row is handshaken in that same cycle counts as free.
REQ-017 SHALL level-shift each pixel on write by inverting bit 7 (equivalent to subtracting 128 from unsigned 0..255), giving signed -128..127.
REQ-018 SHALL drive out_valid high whenever the read bank is full; out_y/out_cr/out_cb and out_idx come from registers.
- Latency: out_valid rises the cycle after the completing eob beat, when the read bank was idle.
REQ-019 SHALL advance out_idx on each cycle with en && out_valid && out_ready.
- On the handshake at idx 7, SHALL clear the bank full flag, toggle the read bank, and reset idx to 0.
REQ-020 SHALL hold out_* stable while out_valid && !out_ready, or while en is low.
REQ-021 SHALL assert out_sof only with idx 0 of a bank whose sof flag is set, and out_eob only with idx 7.
REQ-022 SHALL allow the write of one bank and the read of the other in the same cycle without interaction.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear all of the following:
- out_valid, out_sof, out_eob and err to 0.
- out_idx, out_y, out_cr and out_cb to 0.
- Both bank full and sof flags, and the write position.
- Both bank selects, to bank 0.
REQ-031 SHALL discard any partial block in progress when reset is applied mid-block; storage contents need not be cleared.
REQ-032 SHALL keep err sticky until reset.

Configuration
REQ-040 SHALL, with macro BLOCK_ROW_BUFFER_TRANSPOSE_EN defined, emit columns: lane k of beat c = element(row k, col c).
- Without the macro, SHALL emit rows: lane k of beat r = element(row r, col k).
- Timing, flags and out_idx behaviour SHALL be identical in both builds.

Structure
REQ-050 SHALL take BLOCK_SIZE=8, typedef pix_t (signed 8-bit) and typedef row_t (8 x pix_t) from the shared package block_pkg.
REQ-051 SHALL implement one 8x8 single-plane bank, including its write port and row/column read mux, as sub-module block_bank.
- block_row_buffer SHALL instantiate it six times: 2 banks x 3 planes.

Verification
REQ-060 SHALL cover the following scenarios:
- N=2, one block, Y pixel = 8*line+col, out_ready=1 -> 8 rows, row0 lanes = -128..-121, out_eob only on idx 7, out_valid rises 1 cycle after eob.
- Two back-to-back blocks, out_ready=0 for 40 cycles -> both banks fill; block 1 rows emitted when ready rises, followed by block 2, err=0.
- Third block sob while both banks full -> err=1, third block dropped, first two delivered intact.
- eob at position (3,1) -> err=1, no out_valid; the next well-formed block outputs correctly.
- blk_sof with block sob -> out_sof=1 on idx 0 only; with BLOCK_ROW_BUFFER_TRANSPOSE_EN, row0 lanes = -128,-120,...,-72.
- rst_n low mid-block (after 20 beats) -> all outputs 0 immediately; the next full block is delivered correctly.

Source files
------------

// File: rtl/block_pkg.sv
// Shared block geometry and pixel types for the 8x8 block datapath.
package block_pkg;

  localparam int BLOCK_SIZE = 8;

  typedef logic signed [7:0]      pix_t;
  typedef pix_t [BLOCK_SIZE-1:0] row_t;
  typedef logic [2:0]            idx_t;

  typedef struct packed {
    idx_t line;
    idx_t elem;
  } wpos_t;

endpackage

// File: rtl/block_row_buffer_if.sv
// Beat-in / row-out bus of block_row_buffer; slave is the buffer, master the producer/consumer side.
interface block_row_buffer_if #(
  parameter int N = 2
);
  import block_pkg::*;

  logic              blk_valid;
  logic [N-1:0][7:0] blk_data_y;
  logic [N-1:0][7:0] blk_data_cr;
  logic [N-1:0][7:0] blk_data_cb;
  logic              blk_sob;
  logic              blk_eob;
  logic              blk_sof;

  logic              out_valid;
  logic              out_ready;
  row_t              out_y;
  row_t              out_cr;
  row_t              out_cb;
  idx_t              out_idx;
  logic              out_sof;
  logic              out_eob;

  modport slave (
    input  blk_valid, blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof,
    input  out_ready,
    output out_valid, out_y, out_cr, out_cb, out_idx, out_sof, out_eob
  );

  modport master (
    output blk_valid, blk_data_y, blk_data_cr, blk_data_cb, blk_sob, blk_eob, blk_sof,
    output out_ready,
    input  out_valid, out_y, out_cr, out_cb, out_idx, out_sof, out_eob
  );

endinterface

// File: rtl/block_bank.sv
// One 8x8 single-plane bank: N-lane write port and write-through row/column read mux.
// BLOCK_ROW_BUFFER_TRANSPOSE_EN selects column reads instead of row reads.
module block_bank
  import block_pkg::*;
#(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           we,
  input  idx_t           wr_line,
  input  idx_t           wr_col,
  input  pix_t [N-1:0]   wr_data,
  input  idx_t           rd_idx,
  output row_t           rd_row
);

  pix_t mem [BLOCK_SIZE][BLOCK_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < N; k++) begin
        mem[wr_line][wr_col + idx_t'(k)] <= wr_data[k];
      end
    end
  end

  // Write-through so a row can be registered on the same edge that completes its block.
  always_comb begin
    for (int k = 0; k < BLOCK_SIZE; k++) begin
`ifdef BLOCK_ROW_BUFFER_TRANSPOSE_EN
      rd_row[k] = mem[idx_t'(k)][rd_idx];
      for (int j = 0; j < N; j++) begin
        if (we && wr_line == idx_t'(k) && (wr_col + idx_t'(j)) == rd_idx) begin
          rd_row[k] = wr_data[j];
        end
      end
`else
      rd_row[k] = mem[rd_idx][idx_t'(k)];
      for (int j = 0; j < N; j++) begin
        if (we && wr_line == rd_idx && (wr_col + idx_t'(j)) == idx_t'(k)) begin
          rd_row[k] = wr_data[j];
        end
      end
`endif
    end
  end

endmodule

// File: rtl/block_row_buffer.sv
// Ping-pong 8x8 Y/Cr/Cb block buffer: N-lane beats in, level-shifted rows out with valid/ready.
// Define BLOCK_ROW_BUFFER_TRANSPOSE_EN to emit columns instead of rows.
module block_row_buffer
  import block_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  block_row_buffer_if.slave   bus,
  output logic                err
);

  localparam idx_t LAST_ELEM = idx_t'(BLOCK_SIZE / N - 1);
  localparam idx_t LAST_LINE = idx_t'(BLOCK_SIZE - 1);

  function automatic pix_t level_shift(input logic [7:0] raw);
    return $signed({~raw[7], raw[6:0]});
  endfunction

  logic [1:0] full, full_n;
  logic [1:0] sof_flag, sof_n;
  logic       wr_bank, rd_bank, rd_bank_n;
  logic       dropping;
  wpos_t      wpos, cur_pos, adv_pos;
  idx_t       wr_col, idx_n;

  logic accept, hs, last_hs, wr_free, sob_reject, write_go;
  logic at_end, complete, malformed;

  logic [N-1:0][7:0] raw     [3];
  pix_t [N-1:0]      shifted [3];
  row_t              bank_rows [3][2];

  assign raw[0] = bus.blk_data_y;
  assign raw[1] = bus.blk_data_cr;
  assign raw[2] = bus.blk_data_cb;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < N; k++) begin
        shifted[p][k] = level_shift(raw[p][k]);
      end
    end
  end

  // Write side: position tracking, sob/eob validation, bank-busy rejection.
  assign accept     = en && bus.blk_valid;
  assign hs         = en && bus.out_valid && bus.out_ready;
  assign last_hs    = hs && bus.out_idx == LAST_LINE;
  assign wr_free    = !full[wr_bank] || (last_hs && rd_bank == wr_bank);
  assign sob_reject = accept && bus.blk_sob && !wr_free;
  assign write_go   = accept && wr_free && (bus.blk_sob || !dropping);

  assign cur_pos   = bus.blk_sob ? '0 : wpos;
  assign wr_col    = idx_t'(int'(cur_pos.elem) * N);
  assign at_end    = cur_pos.line == LAST_LINE && cur_pos.elem == LAST_ELEM;
  assign complete  = write_go && bus.blk_eob && at_end;
  assign malformed = write_go && bus.blk_eob && !at_end;

  always_comb begin
    adv_pos = cur_pos;
    if (cur_pos.elem == LAST_ELEM) begin
      adv_pos.elem = '0;
      adv_pos.line = cur_pos.line + 3'd1;
    end else begin
      adv_pos.elem = cur_pos.elem + 3'd1;
    end
  end

  always_comb begin
    full_n = full;
    if (last_hs)  full_n[rd_bank] = 1'b0;
    if (complete) full_n[wr_bank] = 1'b1;
    sof_n = sof_flag;
    if (write_go && bus.blk_sob) sof_n[wr_bank] = bus.blk_sof;
    rd_bank_n = rd_bank ^ last_hs;
    if (last_hs)  idx_n = '0;
    else if (hs)  idx_n = bus.out_idx + 3'd1;
    else          idx_n = bus.out_idx;
  end

  for (genvar p = 0; p < 3; p++) begin : g_plane
    for (genvar b = 0; b < 2; b++) begin : g_bank
      block_bank #(.N(N)) u_bank (
        .clk     (clk),
        .we      (write_go && wr_bank == 1'(b)),
        .wr_line (cur_pos.line),
        .wr_col  (wr_col),
        .wr_data (shifted[p]),
        .rd_idx  (idx_n),
        .rd_row  (bank_rows[p][b])
      );
    end
  end

  // Read side: output registers load the next row whenever the current one is not held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full          <= '0;
      sof_flag      <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wpos          <= '0;
      dropping      <= 1'b0;
      err           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_sof   <= 1'b0;
      bus.out_eob   <= 1'b0;
      bus.out_y     <= '0;
      bus.out_cr    <= '0;
      bus.out_cb    <= '0;
    end else begin
      full     <= full_n;
      sof_flag <= sof_n;
      rd_bank  <= rd_bank_n;
      if (complete) wr_bank <= ~wr_bank;

      if (write_go)        wpos <= bus.blk_eob ? '0 : adv_pos;
      else if (sob_reject) wpos <= '0;

      if (accept) begin
        if (bus.blk_sob)      dropping <= !wr_free && !bus.blk_eob;
        else if (bus.blk_eob) dropping <= 1'b0;
      end

      if (sob_reject || malformed) err <= 1'b1;

      bus.out_valid <= full_n[rd_bank_n];
      if (en && (!bus.out_valid || bus.out_ready)) begin
        bus.out_idx <= idx_n;
        bus.out_sof <= full_n[rd_bank_n] && idx_n == '0 && sof_n[rd_bank_n];
        bus.out_eob <= full_n[rd_bank_n] && idx_n == LAST_LINE;
        if (full_n[rd_bank_n]) begin
          bus.out_y  <= bank_rows[0][rd_bank_n];
          bus.out_cr <= bank_rows[1][rd_bank_n];
          bus.out_cb <= bank_rows[2][rd_bank_n];
        end
      end
    end
  end

endmodule

// File: tb/tb_block_row_buffer.sv
// Directed self-checking bench for block_row_buffer (N=2); honours BLOCK_ROW_BUFFER_TRANSPOSE_EN.
module tb_block_row_buffer;
  import block_pkg::*;

  localparam int N     = 2;
  localparam int EPL   = 8 / N;
  localparam int BEATS = 64 / N;

`ifdef BLOCK_ROW_BUFFER_TRANSPOSE_EN
  localparam logic [63:0] ROW0_SEED0 = 64'hB8B0_A8A0_9890_8880;
`else
  localparam logic [63:0] ROW0_SEED0 = 64'h8786_8584_8382_8180;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic err;

  int checks = 0;
  int errors = 0;

  block_row_buffer_if #(.N(N)) bus ();

  block_row_buffer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Unsigned source pixel for plane 0/1/2 (Y/Cr/Cb) of a block tagged by seed.
  function automatic logic [7:0] pix(input int plane, input int seed, input int l, input int c);
    int v;
    v = 8 * l + c + seed;
    case (plane)
      0:       return 8'(v);
      1:       return 8'(2 * v + 1);
      default: return 8'(255 - v);
    endcase
  endfunction

  function automatic logic [63:0] exp_row(input int plane, input int seed, input int idx);
    logic [63:0] r;
    int e;
    for (int k = 0; k < 8; k++) begin
`ifdef BLOCK_ROW_BUFFER_TRANSPOSE_EN
      e = int'(pix(plane, seed, k, idx)) - 128;
`else
      e = int'(pix(plane, seed, idx, k)) - 128;
`endif
      r[8*k +: 8] = 8'(e);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.blk_valid   = 1'b0;
    bus.blk_sob     = 1'b0;
    bus.blk_eob     = 1'b0;
    bus.blk_sof     = 1'b0;
    bus.blk_data_y  = '0;
    bus.blk_data_cr = '0;
    bus.blk_data_cb = '0;
  endtask

  // Drives nbeats beats on consecutive cycles; returns right after driving the last one.
  task automatic send_beats(input int seed, input bit sof, input int nbeats, input bit eob_last);
    int line, elem, col;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      line = b / EPL;
      elem = b % EPL;
      bus.blk_valid = 1'b1;
      bus.blk_sob   = (b == 0);
      bus.blk_eob   = eob_last && (b == nbeats - 1);
      bus.blk_sof   = sof && (b == 0);
      for (int k = 0; k < N; k++) begin
        col = elem * N + k;
        bus.blk_data_y[k]  = pix(0, seed, line, col);
        bus.blk_data_cr[k] = pix(1, seed, line, col);
        bus.blk_data_cb[k] = pix(2, seed, line, col);
      end
    end
  endtask

  task automatic end_send();
    @(negedge clk);
    idle();
  endtask

  task automatic check_row(input string tag, input int seed, input int idx, input bit sof_exp);
    string t;
    t = $sformatf("%s_r%0d", tag, idx);
    check({t, "_valid"}, bus.out_valid, 1);
    check({t, "_idx"},   bus.out_idx, idx);
    check({t, "_y"},     bus.out_y,  exp_row(0, seed, idx));
    check({t, "_cr"},    bus.out_cr, exp_row(1, seed, idx));
    check({t, "_cb"},    bus.out_cb, exp_row(2, seed, idx));
    check({t, "_sof"},   bus.out_sof, sof_exp);
    check({t, "_eob"},   bus.out_eob, idx == 7);
  endtask

  // Expects out_ready=1 and one row presented per cycle starting now.
  task automatic drain(input string tag, input int seed, input bit sof_first);
    for (int r = 0; r < 8; r++) begin
      check_row(tag, seed, r, sof_first && r == 0);
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_idx"},   bus.out_idx, 0);
    check({tag, "_y"},     bus.out_y, 0);
    check({tag, "_cr"},    bus.out_cr, 0);
    check({tag, "_cb"},    bus.out_cb, 0);
    check({tag, "_sof"},   bus.out_sof, 0);
    check({tag, "_eob"},   bus.out_eob, 0);
    check({tag, "_err"},   err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single block, ready high
    send_beats(0, 1'b0, BEATS, 1'b1);
    check("s1_valid_at_eob", bus.out_valid, 0);
    end_send();
    check("s1_row0_literal", bus.out_y, ROW0_SEED0);
    drain("s1", 0, 1'b0);
    check("s1_done_valid", bus.out_valid, 0);
    check("s1_err", err, 0);

    // two back-to-back blocks with ready held low
    bus.out_ready = 1'b0;
    send_beats(10, 1'b0, BEATS, 1'b1);
    send_beats(20, 1'b0, BEATS, 1'b1);
    end_send();
    repeat (8) @(negedge clk);
    check("s2_hold_valid", bus.out_valid, 1);
    check("s2_hold_idx", bus.out_idx, 0);
    check("s2_hold_y", bus.out_y, exp_row(0, 10, 0));
    bus.out_ready = 1'b1;
    drain("s2a", 10, 1'b0);
    drain("s2b", 20, 1'b0);
    check("s2_done_valid", bus.out_valid, 0);
    check("s2_err", err, 0);

    // third block while both banks full is dropped
    bus.out_ready = 1'b0;
    send_beats(30, 1'b0, BEATS, 1'b1);
    send_beats(40, 1'b0, BEATS, 1'b1);
    send_beats(50, 1'b0, BEATS, 1'b1);
    end_send();
    check("s3_err", err, 1);
    check("s3_hold_y", bus.out_y, exp_row(0, 30, 0));
    bus.out_ready = 1'b1;
    drain("s3a", 30, 1'b0);
    drain("s3b", 40, 1'b0);
    check("s3_done_valid", bus.out_valid, 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst1_err", err, 0);
    check("rst1_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // eob at (3,1) is malformed
    send_beats(60, 1'b0, 3 * EPL + 2, 1'b1);
    end_send();
    repeat (3) @(negedge clk);
    check("s4_err", err, 1);
    check("s4_no_valid", bus.out_valid, 0);
    send_beats(70, 1'b0, BEATS, 1'b1);
    end_send();
    drain("s4", 70, 1'b0);
    check("s4_done_valid", bus.out_valid, 0);

    // start-of-frame block
    send_beats(0, 1'b1, BEATS, 1'b1);
    end_send();
    check("s5_row0_literal", bus.out_y, ROW0_SEED0);
    drain("s5", 0, 1'b1);

    // reset in the middle of a block
    bus.out_ready = 1'b0;
    send_beats(95, 1'b0, BEATS, 1'b1);
    end_send();
    check("s6_pre_valid", bus.out_valid, 1);
    check("s6_pre_err", err, 1);
    send_beats(90, 1'b0, 20, 1'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("s6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_beats(100, 1'b0, BEATS, 1'b1);
    end_send();
    drain("s6", 100, 1'b0);
    check("s6_done_valid", bus.out_valid, 0);
    check("s6_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
